// File: rtl/sata_test_pkg.sv
// Shared definitions for the SATA DMA test engines: LFSR constants, FSM encoding
// and the pattern step function used by both the generator and the TX data path.
package sata_test_pkg;

  localparam logic [31:0] LFSR_MASK     = 32'h8020_0003;
  localparam logic [31:0] SEED_ZERO_SUB = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TX    = 3'd1,
    ST_RX    = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  // An all-zero LFSR would lock up, so a zero seed is replaced in LFSR mode.
  function automatic logic [31:0] seed_sub(input logic mode, input logic [31:0] seed);
    return (mode && seed == 32'h0) ? SEED_ZERO_SUB : seed;
  endfunction

  // Right-shifting Galois LFSR in mode 1, plain increment in mode 0.
  function automatic logic [31:0] pattern_next(input logic mode, input logic [31:0] value);
    if (mode) return {1'b0, value[31:1]} ^ (value[0] ? LFSR_MASK : 32'h0);
    return value + 32'd1;
  endfunction

endpackage

// File: rtl/sata_pattern_gen.sv
// Pattern state register shared by the TX generator and the RX checker.
// load takes priority over advance; mode is sampled on every load/advance.
module sata_pattern_gen
  import sata_test_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        advance,
  input  logic        mode,
  input  logic [31:0] seed,
  output logic [31:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       value <= SEED_ZERO_SUB;
    else if (load)    value <= seed_sub(mode, seed);
    else if (advance) value <= pattern_next(mode, value);
  end

endmodule

// File: rtl/sata_dma_pattern_engine.sv
// DMA pattern engine: writes an incrementing/LFSR dword stream to the TX FIFO
// or checks the same stream read back from the RX FIFO, counting mismatches.
module sata_dma_pattern_engine
  import sata_test_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             DIR,
  input  logic             MODE,
  input  logic [31:0]      SEED,
  input  logic [CNT_W-1:0] DWORD_COUNT,
  input  logic             ABORT,
  input  logic             WRITE_HOLD_IN,
  input  logic             READ_HOLD_IN,
  output logic [31:0]      DMA_TX_DATA_OUT,
  output logic             DMA_TX_WEN_OUT,
  input  logic [31:0]      DMA_RX_DATA_IN,
  output logic             DMA_RX_REN_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] ERR_COUNT,
  output logic [CNT_W-1:0] FIRST_ERR_INDEX,
  output logic             ERR_SEEN
);

  state_t           state, state_next;
  logic             wen, ren;
  logic             start_acc, cmp_en, mismatch;
  logic             mode_q, rd_pending;
  logic [CNT_W-1:0] last_idx, idx, cmp_idx;
  logic [31:0]      gen_value;

  // ABORT wins over START even in IDLE.
  assign start_acc = (state == ST_IDLE) && START && !ABORT;
  // A pending read compare is dropped if the transfer is being cancelled.
  assign cmp_en    = rd_pending && !ABORT;
  assign mismatch  = DMA_RX_DATA_IN != gen_value;

  assign DMA_TX_WEN_OUT = wen;
  assign DMA_RX_REN_OUT = ren;

  sata_pattern_gen u_gen (
    .clk     (CLK),
    .rst_n   (RESET),
    .load    (start_acc),
    .advance (wen || cmp_en),
    .mode    (start_acc ? MODE : mode_q),
    .seed    (SEED),
    .value   (gen_value)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_next = state;
    wen        = 1'b0;
    ren        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_acc) begin
          if (DWORD_COUNT == '0) state_next = ST_FIN;
          else                   state_next = DIR ? ST_RX : ST_TX;
        end
      end
      ST_TX: begin
        wen = !WRITE_HOLD_IN && !ABORT;
        if (ABORT)                         state_next = ST_IDLE;
        else if (wen && idx == last_idx)   state_next = ST_FIN;
      end
      ST_RX: begin
        ren = !READ_HOLD_IN && !ABORT;
        if (ABORT)                         state_next = ST_IDLE;
        else if (ren && idx == last_idx)   state_next = ST_DRAIN;
      end
      ST_DRAIN: state_next = ABORT ? ST_IDLE : ST_FIN;
      ST_FIN:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mode_q          <= 1'b0;
      rd_pending      <= 1'b0;
      last_idx        <= '0;
      idx             <= '0;
      cmp_idx         <= '0;
      DMA_TX_DATA_OUT <= '0;
      BUSY            <= 1'b0;
      DONE            <= 1'b0;
      ERR_COUNT       <= '0;
      FIRST_ERR_INDEX <= '0;
      ERR_SEEN        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here see pre-edge values.
      BUSY       <= state_next != ST_IDLE;
      DONE       <= state_next == ST_FIN;
      rd_pending <= ren;
      if (start_acc) begin
        mode_q          <= MODE;
        last_idx        <= DWORD_COUNT - 1'b1;
        idx             <= '0;
        cmp_idx         <= '0;
        ERR_COUNT       <= '0;
        FIRST_ERR_INDEX <= '0;
        ERR_SEEN        <= 1'b0;
        if (!DIR) DMA_TX_DATA_OUT <= seed_sub(MODE, SEED);
      end else begin
        if (wen) begin
          idx             <= idx + 1'b1;
          DMA_TX_DATA_OUT <= pattern_next(mode_q, gen_value);
        end
        if (ren) idx <= idx + 1'b1;
        if (cmp_en) begin
          cmp_idx <= cmp_idx + 1'b1;
          if (mismatch) begin
            if (ERR_COUNT != '1) ERR_COUNT <= ERR_COUNT + 1'b1;
            if (!ERR_SEEN) begin
              ERR_SEEN        <= 1'b1;
              FIRST_ERR_INDEX <= cmp_idx;
            end
          end
        end
      end
    end
  end

endmodule
